// File: rtl/cmd_frame_gen.sv
// Command frame generator: serialises RF/ALU commands as byte frames to a UART TX
// and assembles the 1- or 2-byte response from UART RX. Optional macro: CMD_GEN_TIMEOUT_EN.
module cmd_frame_gen #(
  parameter int WIDTH_REG = 8,
  parameter int fun       = 4,
  parameter int ADDR      = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   i_Ref_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_type,
  input  logic [ADDR-1:0]        i_cmd_addr,
  input  logic [WIDTH_REG-1:0]   i_cmd_data,
  input  logic [WIDTH_REG-1:0]   i_cmd_opb,
  input  logic [fun-1:0]         i_cmd_fun,
  output logic [WIDTH_REG-1:0]   o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_busy,
  input  logic [WIDTH_REG-1:0]   i_rx_data,
  input  logic                   i_rx_valid,
  output logic [2*WIDTH_REG-1:0] o_rsp_data,
  output logic                   o_rsp_valid,
  output logic                   o_rsp_timeout,
  output logic                   o_done
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

  state_t                 state_q;
  logic [1:0]             type_q;
  logic [ADDR-1:0]        addr_q;
  logic [WIDTH_REG-1:0]   data_q;
  logic [WIDTH_REG-1:0]   opb_q;
  logic [fun-1:0]         fun_q;
  logic [1:0]             idx_q;
  logic                   rsp_cnt_q;
  logic [WIDTH_REG-1:0]   first_q;
  logic [WIDTH_REG-1:0]   tx_data_q;
  logic                   tx_valid_q;
  logic [2*WIDTH_REG-1:0] rsp_data_q;
  logic                   rsp_valid_q;
  logic                   done_q;

  logic [1:0]             nxt_idx;
  logic [1:0]             last_idx;
  logic [WIDTH_REG-1:0]   next_byte_d;

`ifdef CMD_GEN_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0] tmr_q;
  logic             rsp_to_q;
  assign o_rsp_timeout = rsp_to_q;
`else
  assign o_rsp_timeout = 1'b0;
`endif

  function automatic logic [WIDTH_REG-1:0] header(input logic [1:0] t);
    case (t)
      2'd0:    return WIDTH_REG'(8'hAA);
      2'd1:    return WIDTH_REG'(8'hBB);
      2'd2:    return WIDTH_REG'(8'hCC);
      default: return WIDTH_REG'(8'hDD);
    endcase
  endfunction

  // Byte that follows the one currently presented, built from the captured fields.
  always_comb begin
    nxt_idx     = idx_q + 2'd1;
    next_byte_d = '0;
    last_idx    = 2'd1;
    case (type_q)
      2'd0: begin
        last_idx    = 2'd2;
        next_byte_d = (nxt_idx == 2'd1) ? WIDTH_REG'(addr_q) : data_q;
      end
      2'd1: next_byte_d = WIDTH_REG'(addr_q);
      2'd2: begin
        last_idx = 2'd3;
        case (nxt_idx)
          2'd1:    next_byte_d = data_q;
          2'd2:    next_byte_d = opb_q;
          default: next_byte_d = WIDTH_REG'(fun_q);
        endcase
      end
      default: next_byte_d = WIDTH_REG'(fun_q);
    endcase
  end

  always_ff @(posedge i_Ref_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      type_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      opb_q       <= '0;
      fun_q       <= '0;
      idx_q       <= '0;
      rsp_cnt_q   <= 1'b0;
      first_q     <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef CMD_GEN_TIMEOUT_EN
      tmr_q       <= '0;
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef CMD_GEN_TIMEOUT_EN
      rsp_to_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (i_cmd_valid) begin
            type_q     <= i_cmd_type;
            addr_q     <= i_cmd_addr;
            data_q     <= i_cmd_data;
            opb_q      <= i_cmd_opb;
            fun_q      <= i_cmd_fun;
            idx_q      <= 2'd0;
            tx_data_q  <= header(i_cmd_type);
            tx_valid_q <= 1'b1;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (!i_tx_busy) begin
            if (idx_q == last_idx) begin
              tx_valid_q <= 1'b0;
              if (type_q == 2'd0) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                rsp_cnt_q <= 1'b0;
`ifdef CMD_GEN_TIMEOUT_EN
                tmr_q     <= '0;
`endif
                state_q   <= WAIT_RSP;
              end
            end else begin
              idx_q     <= nxt_idx;
              tx_data_q <= next_byte_d;
            end
          end
        end
        WAIT_RSP: begin
          // A byte arriving on the terminal-count cycle wins over the timeout.
          if (i_rx_valid) begin
`ifdef CMD_GEN_TIMEOUT_EN
            tmr_q <= '0;
`endif
            if (type_q == 2'd1) begin
              rsp_data_q  <= {{WIDTH_REG{1'b0}}, i_rx_data};
              rsp_valid_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end else if (!rsp_cnt_q) begin
              first_q   <= i_rx_data;
              rsp_cnt_q <= 1'b1;
            end else begin
              rsp_data_q  <= {i_rx_data, first_q};
              rsp_valid_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end
          end
`ifdef CMD_GEN_TIMEOUT_EN
          else if (tmr_q == TMR_LAST) begin
            rsp_to_q  <= 1'b1;
            done_q    <= 1'b1;
            rsp_cnt_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (state_q == IDLE);
  assign o_tx_data   = tx_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_cmd_frame_gen.sv
// Randomised self-checking bench for cmd_frame_gen; expected frames and responses
// are derived from the command fields, compared cycle by cycle.
module tb_cmd_frame_gen;
  localparam int W  = 8;
  localparam int FW = 4;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [1:0]    i_cmd_type;
  logic [AW-1:0] i_cmd_addr;
  logic [W-1:0]  i_cmd_data;
  logic [W-1:0]  i_cmd_opb;
  logic [FW-1:0] i_cmd_fun;
  logic [W-1:0]  o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_busy;
  logic [W-1:0]  i_rx_data;
  logic          i_rx_valid;
  logic [2*W-1:0] o_rsp_data;
  logic          o_rsp_valid;
  logic          o_rsp_timeout;
  logic          o_done;

  always #5 clk = ~clk;

  cmd_frame_gen #(.WIDTH_REG(W), .fun(FW), .ADDR(AW), .TIMEOUT(TO)) dut (
    .i_Ref_clk    (clk),
    .i_rst        (i_rst),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_type   (i_cmd_type),
    .i_cmd_addr   (i_cmd_addr),
    .i_cmd_data   (i_cmd_data),
    .i_cmd_opb    (i_cmd_opb),
    .i_cmd_fun    (i_cmd_fun),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_busy    (i_tx_busy),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_timeout(o_rsp_timeout),
    .o_done       (o_done)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] rsp_model = '0;
  logic [7:0]  exp_fr[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_frame(input logic [1:0] t, input logic [AW-1:0] a, input logic [7:0] d,
                             input logic [7:0] b, input logic [FW-1:0] f);
    exp_fr.delete();
    case (t)
      2'd0: begin exp_fr.push_back(8'hAA); exp_fr.push_back(8'(a)); exp_fr.push_back(d); end
      2'd1: begin exp_fr.push_back(8'hBB); exp_fr.push_back(8'(a)); end
      2'd2: begin exp_fr.push_back(8'hCC); exp_fr.push_back(d); exp_fr.push_back(b);
                  exp_fr.push_back(8'(f)); end
      default: begin exp_fr.push_back(8'hDD); exp_fr.push_back(8'(f)); end
    endcase
  endtask

  task automatic junk_fields();
    i_cmd_type = 2'($urandom_range(3));
    i_cmd_addr = AW'($urandom_range(15));
    i_cmd_data = 8'($urandom_range(255));
    i_cmd_opb  = 8'($urandom_range(255));
    i_cmd_fun  = FW'($urandom_range(15));
  endtask

  // Full command: accept, send frame under busy stalls, feed response, check result.
  task automatic do_cmd(input logic [1:0] t, input logic [AW-1:0] a, input logic [7:0] d,
                        input logic [7:0] b, input logic [FW-1:0] f, input int busy_pct,
                        input int busy_run, input bit early_rx, input bit hold_valid,
                        input int gap, input logic [7:0] r0, input logic [7:0] r1);
    int  guard;
    int  idx;
    int  brun;
    bit  busy;
    bit  rdy;
    int  nb;
    logic [15:0] exp_rsp;
    chk("rsp_hold", o_rsp_data, rsp_model);
    build_frame(t, a, d, b, f);
    i_cmd_valid = 1'b1;
    i_cmd_type = t; i_cmd_addr = a; i_cmd_data = d; i_cmd_opb = b; i_cmd_fun = f;
    if (early_rx) begin i_rx_valid = 1'b1; i_rx_data = 8'($urandom_range(255)); end
    guard = 0;
    do begin
      rdy = o_cmd_ready;
      tick();
      guard++;
    end while (!rdy && guard < 200);
    chk("accept_latency", guard, 1);
    i_cmd_valid = hold_valid;
    junk_fields();
    i_rx_valid = 1'b0;
    idx = 0; guard = 0; brun = busy_run;
    while (idx < exp_fr.size() && guard < 300) begin
      chk("tx_valid", o_tx_valid, 1);
      chk("tx_data", o_tx_data, exp_fr[idx]);
      chk("ready_busy", o_cmd_ready, 0);
      chk("done_send", o_done, 0);
      if (idx == 2 && brun > 0) begin
        busy = 1'b1;
        brun--;
      end else begin
        busy = ($urandom_range(99) < busy_pct);
      end
      i_tx_busy = busy;
      if (early_rx) begin
        i_rx_valid = 1'($urandom_range(1));
        i_rx_data  = 8'($urandom_range(255));
      end
      if (hold_valid) junk_fields();
      tick();
      guard++;
      if (!busy) idx++;
    end
    chk("send_complete", idx, exp_fr.size());
    i_tx_busy = 1'b0;
    i_rx_valid = 1'b0;
    chk("tx_valid_gap", o_tx_valid, 0);
    if (t == 2'd0) begin
      chk("done_t0", o_done, 1);
      chk("rsp_valid_t0", o_rsp_valid, 0);
      chk("ready_t0", o_cmd_ready, 1);
      chk("rsp_hold_t0", o_rsp_data, rsp_model);
    end else begin
      chk("done_wait", o_done, 0);
      nb = (t == 2'd1) ? 1 : 2;
      for (int k = 0; k < nb; k++) begin
        for (int g = 0; g < gap; g++) begin
          chk("wait_rsp_valid", o_rsp_valid, 0);
          chk("wait_timeout", o_rsp_timeout, 0);
          chk("wait_ready", o_cmd_ready, 0);
          tick();
        end
        i_rx_valid = 1'b1;
        i_rx_data  = (k == 0) ? r0 : r1;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom_range(255));
      end
      exp_rsp = (t == 2'd1) ? {8'h00, r0} : {r1, r0};
      chk("rsp_valid", o_rsp_valid, 1);
      chk("rsp_done", o_done, 1);
      chk("rsp_data", o_rsp_data, exp_rsp);
      chk("rsp_no_timeout", o_rsp_timeout, 0);
      rsp_model = exp_rsp;
    end
    if (!hold_valid) begin
      tick();
      chk("done_pulse_end", o_done, 0);
      chk("rsp_valid_pulse_end", o_rsp_valid, 0);
      chk("ready_idle", o_cmd_ready, 1);
    end
  endtask

  // Accept a frame with no stalls and stop in the response wait.
  task automatic start_frame(input logic [1:0] t, input logic [7:0] d, input logic [7:0] b,
                             input logic [FW-1:0] f);
    build_frame(t, '0, d, b, f);
    i_cmd_valid = 1'b1;
    i_cmd_type = t; i_cmd_addr = '0; i_cmd_data = d; i_cmd_opb = b; i_cmd_fun = f;
    tick();
    i_cmd_valid = 1'b0;
    for (int k = 0; k < exp_fr.size(); k++) begin
      chk("sf_tx_data", o_tx_data, exp_fr[k]);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_tx_busy = 1'b0; i_rx_valid = 1'b0; i_rx_data = '0;
    i_cmd_type = '0; i_cmd_addr = '0; i_cmd_data = '0; i_cmd_opb = '0; i_cmd_fun = '0;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_ready", o_cmd_ready, 1);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_rsp_data", o_rsp_data, 0);
    chk("rst_timeout", o_rsp_timeout, 0);
    chk("rst_done", o_done, 0);
    i_rx_valid = 1'b1; i_rx_data = 8'h5C;
    tick();
    i_rx_valid = 1'b0;
    chk("idle_rx_ignored", o_rsp_valid, 0);

    do_cmd(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0, 0, 0, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    do_cmd(2'd2, 4'd0, 8'h12, 8'h34, 4'd1, 0, 4, 1'b0, 1'b0, 2, 8'h46, 8'h00);
    do_cmd(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 0, 0, 1'b1, 1'b0, 3, 8'h7E, 8'h00);
    do_cmd(2'd3, 4'd0, 8'h00, 8'h00, 4'hF, 30, 0, 1'b0, 1'b1, 1, 8'hA5, 8'h3C);
    do_cmd(2'd1, 4'hF, 8'h00, 8'h00, 4'd0, 0, 0, 1'b0, 1'b0, 0, 8'hFF, 8'h00);

    start_frame(2'd2, 8'h12, 8'h34, 4'd1);
    rsp_model = rsp_model;
    i_rst = 1'b0;
    build_frame(2'd2, '0, 8'h21, 8'h43, 4'd7);
    i_cmd_valid = 1'b1; i_cmd_type = 2'd2; i_cmd_data = 8'h21; i_cmd_opb = 8'h43; i_cmd_fun = 4'd7;
    i_rx_valid = 1'b1; i_rx_data = 8'h01;
    tick();
    i_rx_valid = 1'b0;
    tick();
    i_rx_valid = 1'b1; i_rx_data = 8'h02;
    tick();
    i_rx_valid = 1'b0;
    rsp_model = 16'h0201;
    chk("prefill_rsp", o_rsp_data, rsp_model);
    chk("reset_path_idle", o_cmd_ready, 1);
    tick();
    i_cmd_valid = 1'b0;
    chk("mid_b0", o_tx_data, 8'hCC);
    tick();
    chk("mid_b1", o_tx_data, 8'h21);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mid_rst_tx_valid", o_tx_valid, 0);
    chk("mid_rst_ready", o_cmd_ready, 1);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_tx_data", o_tx_data, 0);
    chk("mid_rst_rsp_data", o_rsp_data, 0);
    rsp_model = '0;
    tick();
    chk("mid_rst_done_after", o_done, 0);
    do_cmd(2'd0, 4'd9, 8'hC3, 8'h00, 4'd0, 20, 0, 1'b0, 1'b0, 0, 8'h00, 8'h00);

`ifdef CMD_GEN_TIMEOUT_EN
    start_frame(2'd3, 8'h00, 8'h00, 4'd2);
    i_rx_valid = 1'b1; i_rx_data = 8'h99;
    tick();
    i_rx_valid = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
      if (!o_rsp_timeout) chk("to_no_early_done", o_done, 0);
    end while (!o_rsp_timeout && cnt < 40);
    chk("timeout_cycles", cnt, TO);
    chk("timeout_done", o_done, 1);
    chk("timeout_rsp_valid", o_rsp_valid, 0);
    chk("timeout_rsp_hold", o_rsp_data, rsp_model);
    chk("timeout_ready", o_cmd_ready, 1);
    tick();
    chk("timeout_pulse_end", o_rsp_timeout, 0);

    start_frame(2'd3, 8'h00, 8'h00, 4'd5);
    i_rx_valid = 1'b1; i_rx_data = 8'h21;
    tick();
    i_rx_valid = 1'b0;
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      chk("tc_no_timeout", o_rsp_timeout, 0);
    end
    i_rx_valid = 1'b1; i_rx_data = 8'h43;
    tick();
    i_rx_valid = 1'b0;
    chk("tc_rsp_valid", o_rsp_valid, 1);
    chk("tc_timeout", o_rsp_timeout, 0);
    chk("tc_rsp_data", o_rsp_data, 16'h4321);
    rsp_model = 16'h4321;
    tick();
`else
    do_cmd(2'd2, 4'd0, 8'h0F, 8'hF0, 4'd3, 10, 0, 1'b0, 1'b0, 40, 8'h11, 8'h22);
    cnt = 0;
`endif

    for (int n = 0; n < 40; n++) begin
      do_cmd(2'($urandom_range(3)), AW'($urandom_range(15)), 8'($urandom_range(255)),
             8'($urandom_range(255)), FW'($urandom_range(15)), $urandom_range(70), 0,
             1'($urandom_range(1)), (n % 7 == 3), $urandom_range(10),
             8'($urandom_range(255)), 8'($urandom_range(255)));
    end
    i_cmd_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmd_frame_gen.md
CMD_FRAME_GEN -- requirements
Module: cmd_frame_gen

Interface
REQ-001 SHALL have parameter WIDTH_REG, default 8, byte/register data width.
REQ-002 SHALL have parameter fun, default 4, ALU function code width.
REQ-003 SHALL have parameter ADDR, default 4, register-file address width.
REQ-004 SHALL have parameter TIMEOUT, default 1023, maximum idle cycles allowed between response bytes.
REQ-005 SHALL have port i_Ref_clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port i_rst  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port i_cmd_valid  in  1  command request.
REQ-008 SHALL have port o_cmd_ready  out  1  command accepted when high with i_cmd_valid.
REQ-009 SHALL have port i_cmd_type  in  2  0=RF write, 1=RF read, 2=ALU with operands, 3=ALU no operands.
REQ-010 SHALL have port i_cmd_addr  in  ADDR  register address.
REQ-011 SHALL have port i_cmd_data  in  WIDTH_REG  write data or operand A.
REQ-012 SHALL have port i_cmd_opb  in  WIDTH_REG  operand B.
REQ-013 SHALL have port i_cmd_fun  in  fun  ALU function code.
REQ-014 SHALL have port o_tx_data  out  WIDTH_REG  frame byte to UART TX.
REQ-015 SHALL have port o_tx_valid  out  1  o_tx_data valid.
REQ-016 SHALL have port i_tx_busy  in  1  UART TX busy; a byte transfers on a cycle with o_tx_valid=1 and i_tx_busy=0.
REQ-017 SHALL have port i_rx_data  in  WIDTH_REG  response byte from UART RX.
REQ-018 SHALL have port i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
REQ-019 SHALL have port o_rsp_data  out  2*WIDTH_REG  assembled response.
REQ-020 SHALL have port o_rsp_valid  out  1  one-cycle pulse; o_rsp_data valid.
REQ-021 SHALL have port o_rsp_timeout  out  1  one-cycle pulse; response abandoned.
REQ-022 SHALL have port o_done  out  1  one-cycle pulse at the end of every command.

Function
REQ-023 SHALL use states IDLE, SEND, WAIT_RSP; o_cmd_ready=1 only in IDLE.
REQ-024 SHALL capture all i_cmd_* fields on acceptance and go to SEND; o_tx_valid SHALL rise the next cycle.
REQ-025 SHALL send frames: type0 AA,addr,data; type1 BB,addr; type2 CC,A,B,fun; type3 DD,fun. addr and fun SHALL be zero-extended to WIDTH_REG.
REQ-026 SHALL hold o_tx_data and o_tx_valid stable while i_tx_busy=1 and advance the byte index only on transfer.
REQ-027 SHALL deassert o_tx_valid between frames and present the next byte the cycle after a transfer.
REQ-028 After the last byte transfers: type0 SHALL pulse o_done and go to IDLE; types 1-3 SHALL go to WAIT_RSP.
REQ-029 SHALL expect 1 response byte for type1 and 2 bytes, LSB first, for types 2/3.
REQ-030 type1 SHALL output o_rsp_data={8'h00,byte}; types 2/3 SHALL output {second,first}. o_rsp_valid and o_done SHALL pulse the cycle after the final byte, then go to IDLE.
REQ-031 SHALL ignore i_rx_valid in IDLE and SEND (byte dropped).
REQ-032 SHALL hold o_rsp_data until the next o_rsp_valid.

Reset
REQ-033 With i_rst=1 at a clock edge, SHALL go to IDLE and clear byte and response counters, the timeout counter and o_rsp_data; o_tx_valid, o_rsp_valid, o_rsp_timeout and o_done SHALL be 0; o_tx_data SHALL be 0; o_cmd_ready SHALL be 1.
REQ-034 Reset in mid-frame or mid-wait SHALL abort with no o_done pulse.

Configuration
REQ-035 With macro CMD_GEN_TIMEOUT_EN defined: in WAIT_RSP, a counter SHALL clear on entry and on each i_rx_valid, and increment otherwise. On reaching TIMEOUT, the block SHALL pulse o_rsp_timeout and o_done, discard partial data, leave o_rsp_data unchanged and go to IDLE.
REQ-036 If i_rx_valid coincides with the terminal count, SHALL accept the byte and not time out.
REQ-037 Without CMD_GEN_TIMEOUT_EN: no counter; WAIT_RSP waits indefinitely; o_rsp_timeout SHALL be tied to 0.

Verification
REQ-038 type0 addr=3 data=5A, i_tx_busy=0 -> bytes AA,03,5A on 3 consecutive transfers; o_done 1 cycle later; no o_rsp_valid.
REQ-039 type2 A=12 B=34 fun=1, i_tx_busy toggled high 4 cycles mid-frame -> CC,12,34,01 sent with o_tx_data held during busy; rx 46,00 -> o_rsp_data=0046, o_rsp_valid 1 pulse.
REQ-040 type1 addr=2, rx strobe sent during SEND then valid byte 7E -> early byte dropped; o_rsp_data=007E.
REQ-041 CMD_GEN_TIMEOUT_EN, TIMEOUT=16, type3 fun=2, one rx byte then silence -> o_rsp_timeout and o_done pulse exactly 16 cycles after that byte; o_rsp_data unchanged.
REQ-042 i_rst asserted during byte 2 of a type2 frame -> next cycle o_tx_valid=0, o_cmd_ready=1, no o_done; a new command is then accepted normally.
REQ-043 i_cmd_valid held high during a busy command -> not accepted until IDLE; its fields are captured only then.
